hilo_mdu: RTL
=============

HILO_MDU -- requirements
Module: hilo_mdu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width and the width of each of HI and LO; legal values are even integers 4 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled each cycle.
REQ-005 The block SHALL have port op, input, 3 bits: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 110/111 no-op.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: a is the multiplicand/dividend/MT source, b is the multiplier/divisor.
REQ-007 The block SHALL have port flush, input, 1 bit: exception/eret cancel.
REQ-008 The block SHALL have port rd_sel, input, 1 bit: 1 reads HI, 0 reads LO.
REQ-009 The block SHALL have port busy, output, 1 bit: the pipeline must stall while high.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when a mul/div result becomes visible.
REQ-011 The block SHALL have port rhl_out, output, WIDTH bits: HI when rd_sel=1, LO when rd_sel=0, combinational from the registers.

Function
REQ-012 The state machine SHALL have states IDLE, MUL (iterative shift-add), DIV (restoring, one quotient bit per cycle) and FIX (sign correction and HI/LO write).
REQ-013 An accepted request SHALL be start=1, flush=0 and state=IDLE; start in any other state SHALL be ignored.
REQ-014 On an accepted MULTU/MULT/DIVU/DIV, the operand magnitudes and result signs SHALL be latched, the count loaded with WIDTH, and the next state SHALL be MUL or DIV.
REQ-015 MUL/DIV SHALL decrement the count each cycle and go to FIX after WIDTH cycles; FIX SHALL always return to IDLE.
REQ-016 HI/LO SHALL be written at the edge ending FIX; for a request accepted in cycle 0, the result SHALL be visible and done=1 in cycle WIDTH+2 (cycle 34 for WIDTH=32).
REQ-017 busy SHALL equal (next_state != IDLE), so busy is high in the accept cycle and low in the FIX cycle.
REQ-018 The multiply result SHALL be the 2*WIDTH-bit product, with HI the upper half and LO the lower half; MULT is signed, MULTU unsigned.
REQ-019 The divide result SHALL be LO=quotient, HI=remainder; for DIV the quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-020 Divide by zero SHALL give LO=all ones, HI=a, with full latency and no error flag.
REQ-021 Signed DIV of the most negative value by -1 SHALL give LO=most negative value, HI=0.
REQ-022 MTHI/MTLO, when accepted, SHALL write a into HI/LO at the same edge with no busy and no done.
REQ-023 flush=1 in any cycle SHALL force the next state to IDLE and suppress any HI/LO write at that edge; HI/LO keep their pre-operation values, and no done follows.
REQ-024 When start and flush are both 1, nothing SHALL be accepted.
REQ-025 done SHALL be registered, high exactly one cycle per completed mul/div, and never high for MT ops or flushed ops.

Reset
REQ-026 While rst=1 at an edge, the block SHALL set state=IDLE, HI=0, LO=0, count=0, done=0 and clear the internal datapath registers; busy SHALL read 0 after the edge.
REQ-027 rst SHALL take priority over start and flush; reset mid-operation SHALL abandon the operation with no done pulse.

Configuration
REQ-028 When macro MDU_FAST_MUL_EN is defined, MULT/MULTU SHALL use a single-cycle combinational WIDTH x WIDTH multiplier: HI/LO written at the accept edge, done=1 in cycle 1, busy never high for multiply; DIV is unchanged.
REQ-029 When MDU_FAST_MUL_EN is undefined, multiply SHALL use the iterative MUL/FIX path with WIDTH+2 latency and no hardware multiplier inferred.

Verification
REQ-030 The bench SHALL check: WIDTH=32, MULT a=0xFFFFFFFF b=0x00000002 -> HI=0xFFFFFFFF LO=0xFFFFFFFE, done in cycle 34 (cycle 1 with MDU_FAST_MUL_EN).
REQ-031 The bench SHALL check: MULTU with the same operands -> HI=0x00000001 LO=0xFFFFFFFE.
REQ-032 The bench SHALL check: DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF; busy high in cycles 0-32, low in cycle 33, done in cycle 34.
REQ-033 The bench SHALL check: DIVU a=5 b=0 -> LO=0xFFFFFFFF HI=0x00000005; DIV a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000 HI=0.
REQ-034 The bench SHALL check: MTHI a=0x12345678 preloaded, then DIV, then flush at cycle 10 -> busy low cycle 11, HI=0x12345678, no done; a new start in cycle 11 is accepted.
REQ-035 The bench SHALL check: start during busy ignored; start+flush same cycle -> stays IDLE; rst at cycle 5 of DIV -> HI=LO=0, no done.

Source files
------------

// File: rtl/hilo_mdu.sv
`default_nettype none
// ============================================================================
// hilo_mdu -- HI/LO multiply/divide unit (iterative shift-add multiply,
//             restoring divide). Define MDU_FAST_MUL_EN for a one-cycle multiply.
// Revision 1.0
// ============================================================================
module hilo_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             rd_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rhl_out
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   acc_q,   acc_d;    // partial product high half / partial remainder
  logic [WIDTH-1:0] work_q,  work_d;   // multiplier shifting out / dividend->quotient
  logic [WIDTH-1:0] opnd_q,  opnd_d;   // multiplicand magnitude / divisor magnitude
  logic             neg_q,   neg_d;    // product or quotient must be negated
  logic             rneg_q,  rneg_d;   // remainder must be negated
  logic             dz_q,    dz_d;
  logic             div_q,   div_d;
  logic [WIDTH-1:0] hi_q,    hi_d;
  logic [WIDTH-1:0] lo_q,    lo_d;
  logic             done_q,  done_d;

  logic               accept;
  logic               is_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod_mag, prod_res;
  logic [WIDTH-1:0]   quo_res, rem_res;

  assign accept    = start && !flush && (state_q == S_IDLE);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = is_signed && a[WIDTH-1];
  assign b_neg     = is_signed && b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  assign mul_sum   = work_q[0] ? (acc_q + {1'b0, opnd_q}) : acc_q;
  assign div_shift = {acc_q[WIDTH-1:0], work_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opnd_q};

  // Unsigned core results; signs are applied only once, in FIX.
  assign prod_mag  = {acc_q[WIDTH-1:0], work_q};
  assign prod_res  = neg_q ? -prod_mag : prod_mag;
  assign quo_res   = dz_q ? {WIDTH{1'b1}} : (neg_q ? -work_q : work_q);
  assign rem_res   = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_mag, fast_res;
  assign fast_mag = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
  assign fast_res = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    work_d  = work_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    div_d   = div_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_MULTU, OP_MULT: begin
`ifdef MDU_FAST_MUL_EN
              hi_d   = fast_res[2*WIDTH-1:WIDTH];
              lo_d   = fast_res[WIDTH-1:0];
              done_d = 1'b1;
`else
              state_d = S_MUL;
              count_d = CW'(WIDTH);
              acc_d   = '0;
              work_d  = b_mag;
              opnd_d  = a_mag;
              neg_d   = a_neg ^ b_neg;
              rneg_d  = 1'b0;
              dz_d    = 1'b0;
              div_d   = 1'b0;
`endif
            end
            OP_DIVU, OP_DIV: begin
              state_d = S_DIV;
              count_d = CW'(WIDTH);
              acc_d   = '0;
              work_d  = a_mag;
              opnd_d  = b_mag;
              neg_d   = a_neg ^ b_neg;
              rneg_d  = a_neg;
              dz_d    = (b == '0);
              div_d   = 1'b1;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d   = {1'b0, mul_sum[WIDTH:1]};
        work_d  = {mul_sum[0], work_q[WIDTH-1:1]};
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = S_FIX;
      end
      S_DIV: begin
        // A clear sign bit on the trial means the divisor fit: keep it, shift in a 1.
        if (!div_trial[WIDTH]) begin
          acc_d  = div_trial;
          work_d = {work_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d  = div_shift;
          work_d = {work_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (div_q) begin
          hi_d = rem_res;
          lo_d = quo_res;
        end else begin
          hi_d = prod_res[2*WIDTH-1:WIDTH];
          lo_d = prod_res[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Cancel wins over everything: no write, no completion, back to idle.
    if (flush) begin
      state_d = S_IDLE;
      count_d = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      work_q  <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      div_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      work_q  <= work_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_d != S_IDLE);
  assign done    = done_q;
  assign rhl_out = rd_sel ? hi_q : lo_q;

endmodule
`default_nettype wire
